temp_acquire: RTL
=================

Name: temp_acquire

Overview:
- Upstream acquisition stage for the pipe temperature controller.
- Reads a 12-bit serial ADC (SPI mode 0, read-only) that digitises the pipe temperature sensor.
- Averages 2^AVG_LOG2 good samples and drives the controller's 8-bit Temp_Data, plus a one-cycle Temp_Valid strobe.
- Detects malformed frames and raises a sticky Sensor_Fault after repeated consecutive errors.

Parameters:
- CLK_DIV, 25: Clock cycles per SCLK half-period; minimum 2.
- AVG_LOG2, 2: log2 of the number of good samples averaged per published value; range 0..4.
- SAMPLE_GAP, 1000: Clock cycles with CS_n high between frames; minimum 1.
- ERR_LIMIT, 3: consecutive frame errors that set Sensor_Fault.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Enable  in  1  level; high = run continuous conversions.
- Adc_Miso  in  1  ADC serial data, MSB first, changes after SCLK falling edge.
- Adc_Sclk  out  1  serial clock, idle low.
- Adc_Cs_n  out  1  ADC chip select, active low.
- Temp_Data  out  8  averaged temperature code to the controller; held between updates.
- Temp_Valid  out  1  one-cycle pulse when Temp_Data updates.
- Sensor_Fault  out  1  sticky fault flag.
- Frame_Err  out  1  one-cycle pulse per rejected frame.

Behaviour:
- Reset values (asynchronous, effective immediately, including mid-frame):
  - Adc_Cs_n=1, Adc_Sclk=0.
  - Temp_Data=0, Temp_Valid=0, Sensor_Fault=0, Frame_Err=0.
  - Accumulator, sample count and error count = 0; state = IDLE.
- All outputs are registered.
- FSM states: IDLE, SETUP, SHIFT, HOLD, CHECK, GAP.
- IDLE: CS_n=1. Moves to SETUP on the first cycle Enable=1.
- SETUP: CS_n=0 for CLK_DIV cycles, SCLK=0, then SHIFT.
- SHIFT:
  - 16 SCLK periods, each CLK_DIV cycles high then CLK_DIV cycles low.
  - Adc_Miso is shifted into a 16-bit register on the Clock edge where SCLK goes 0->1.
- HOLD: after the 16th falling edge, CS_n stays 0 for CLK_DIV cycles, then CS_n=1 and the FSM goes to CHECK.
- Frame timing: CS_n low for exactly 34*CLK_DIV cycles.
- CHECK (1 cycle):
  - Frame = 4 leading bits (must be 0000) followed by 12 data bits.
  - Leading bits nonzero:
    - Frame_Err pulses; sample discarded; accumulator untouched.
    - Error count increments, saturating at ERR_LIMIT.
    - Error count reaching ERR_LIMIT sets Sensor_Fault.
  - Leading bits zero:
    - Error count cleared; 12-bit sample added to the (12+AVG_LOG2)-bit accumulator.
    - Sample count increments.
- Publish: when the sample count reaches 2^AVG_LOG2 in CHECK:
  - On the next Clock, Temp_Data <= accumulated_sum >> (AVG_LOG2+4), truncating. The result always fits 8 bits, so no saturation.
  - Temp_Valid=1 for that one cycle; accumulator and count clear in the same cycle.
- Sensor_Fault stays set until Reset. Acquisition and publishing continue while it is set.
- GAP: CS_n=1 for SAMPLE_GAP cycles. Then SETUP if Enable=1, else IDLE.
- Enable falling mid-frame: the current frame completes normally through CHECK/GAP, then the FSM parks in IDLE. The partial accumulation is kept and resumes when Enable returns.
- Temp_Data is never altered except by a publish or by Reset.

Decomposition:
- Package temp_acq_pkg holds:
  - the FSM state enum;
  - FRAME_BITS=16, ADC_BITS=12, LEAD_BITS=4;
  - the helper constant for the output shift (ADC_BITS-8).
- Sub-module spi_adc_rx: SCLK generation, CS_n sequencing, shift register and a frame_done strobe carrying the 16-bit frame.
- Top level keeps frame check, averaging, fault logic and the GAP/IDLE control.

Test Plan:
- CLK_DIV=2, AVG_LOG2=2, Enable=1, ADC model returns 0x0FA0 (4000) four times -> one Temp_Valid pulse with Temp_Data=0xFA (250); CS_n low 68 cycles per frame; SCLK period 4 cycles; 16 rising edges per frame.
- Frames 4000, 4000, 2400, 2400 -> Temp_Data=200 (0xC8); a following set of four 0x0960 frames -> Temp_Data=150.
- Frame 0x8FA0 inserted among four 4000 frames -> Frame_Err pulses once; five frames are consumed before the publish; Temp_Data=250; Sensor_Fault stays 0.
- Three consecutive 0xF000 frames -> Sensor_Fault=1 after the third CHECK; then four good 4000 frames -> Temp_Data=250 published with Sensor_Fault still 1.
- Reset asserted during the 8th SCLK bit:
  - CS_n=1 and SCLK=0 in the same cycle; Temp_Data=0.
  - After release with Enable=1, the first SETUP starts on the next edge.
- Enable dropped during SHIFT:
  - The frame completes (CS_n low for the full 68 cycles), GAP elapses, then IDLE with no further CS_n falls.
  - Re-enabling after two good samples had been accumulated -> a publish occurs after two more good frames.

Source files
------------

// File: rtl/temp_acq_pkg.sv
// Shared types and frame-format constants for the temperature acquisition slice.
package temp_acq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    CHECK,
    GAP
  } state_t;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADC_BITS   = 12;
  localparam int unsigned LEAD_BITS  = 4;
  // Right shift that maps a 12-bit ADC code onto the 8-bit controller code
  localparam int unsigned OUT_SHIFT  = ADC_BITS - 8;

endpackage

// File: rtl/spi_adc_rx.sv
// SPI mode-0 read-only receiver: CS_n sequencing, SCLK generation and the 16-bit shift register.
module spi_adc_rx
  import temp_acq_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  start,
  input  logic                  adc_miso,
  output logic                  adc_sclk,
  output logic                  adc_cs_n,
  output logic                  frame_done_c,
  output logic [FRAME_BITS-1:0] frame
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(FRAME_BITS);

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    sclk_q, sclk_d;
  logic                    cs_n_q, cs_n_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic                    phase_end;

  assign phase_end = (cnt_q == DIV_W'(CLK_DIV - 1));

  // Each phase (setup, high, low, hold) lasts CLK_DIV cycles; transitions happen on phase_end
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + DIV_W'(1);
    bit_d        = bit_q;
    sclk_d       = sclk_q;
    cs_n_d       = cs_n_q;
    shreg_d      = shreg_q;
    frame_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
        end
      end
      SETUP: begin
        if (phase_end) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b1;
          shreg_d = {shreg_q[FRAME_BITS-2:0], adc_miso};
        end
      end
      SHIFT: begin
        if (phase_end) begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
            state_d = HOLD;
          end else begin
            sclk_d  = 1'b1;
            bit_d   = bit_q + BIT_W'(1);
            shreg_d = {shreg_q[FRAME_BITS-2:0], adc_miso};
          end
        end
      end
      HOLD: begin
        if (phase_end) begin
          state_d      = IDLE;
          cnt_d        = '0;
          cs_n_d       = 1'b1;
          frame_done_c = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sclk_d  = 1'b0;
        cs_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      shreg_q <= shreg_d;
    end
  end

  assign adc_sclk = sclk_q;
  assign adc_cs_n = cs_n_q;
  assign frame    = shreg_q;

endmodule

// File: rtl/temp_acquire.sv
// Pipe temperature acquisition: frame validation, averaging, fault tracking and frame pacing.
module temp_acquire
  import temp_acq_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned SAMPLE_GAP = 1000,
  parameter int unsigned ERR_LIMIT  = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Adc_Miso,
  output logic       Adc_Sclk,
  output logic       Adc_Cs_n,
  output logic [7:0] Temp_Data,
  output logic       Temp_Valid,
  output logic       Sensor_Fault,
  output logic       Frame_Err
);

  localparam int unsigned ACC_W = ADC_BITS + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam int unsigned NAVG  = 1 << AVG_LOG2;
  localparam int unsigned ERR_W = $clog2(ERR_LIMIT + 1);
  localparam int unsigned GAP_W = $clog2(SAMPLE_GAP + 1);

  state_t                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      smp_cnt_q, smp_cnt_d;
  logic [ERR_W-1:0]      err_cnt_q, err_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [7:0]            temp_data_q, temp_data_d;
  logic                  temp_valid_q, temp_valid_d;
  logic                  fault_q, fault_d;
  logic                  frame_err_q, frame_err_d;

  logic                  start_c;
  logic                  frame_done_c;
  logic [FRAME_BITS-1:0] frame;
  logic [ACC_W-1:0]      sum_c;
  logic [CNT_W-1:0]      cnt_inc_c;
  logic                  gap_last_c;

  spi_adc_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .Clock        (Clock),
    .Reset        (Reset),
    .start        (start_c),
    .adc_miso     (Adc_Miso),
    .adc_sclk     (Adc_Sclk),
    .adc_cs_n     (Adc_Cs_n),
    .frame_done_c (frame_done_c),
    .frame        (frame)
  );

  assign gap_last_c = (gap_cnt_q == GAP_W'(SAMPLE_GAP - 1));
  assign start_c    = Enable && ((state_q == IDLE) || ((state_q == GAP) && gap_last_c));
  assign sum_c      = acc_q + ACC_W'(frame[ADC_BITS-1:0]);
  assign cnt_inc_c  = smp_cnt_q + CNT_W'(1);

  // SETUP here covers the whole serial frame (setup, shift, hold) run by u_rx
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    smp_cnt_d    = smp_cnt_q;
    err_cnt_d    = err_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    temp_data_d  = temp_data_q;
    temp_valid_d = 1'b0;
    fault_d      = fault_q;
    frame_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Enable) state_d = SETUP;
      end
      SETUP: begin
        if (frame_done_c) state_d = CHECK;
      end
      CHECK: begin
        state_d   = GAP;
        gap_cnt_d = '0;
        if (frame[FRAME_BITS-1 -: LEAD_BITS] != '0) begin
          frame_err_d = 1'b1;
          if (err_cnt_q != ERR_W'(ERR_LIMIT)) err_cnt_d = err_cnt_q + ERR_W'(1);
          if (err_cnt_d == ERR_W'(ERR_LIMIT)) fault_d = 1'b1;
        end else begin
          err_cnt_d = '0;
          if (cnt_inc_c == CNT_W'(NAVG)) begin
            temp_data_d  = 8'(sum_c >> (AVG_LOG2 + OUT_SHIFT));
            temp_valid_d = 1'b1;
            acc_d        = '0;
            smp_cnt_d    = '0;
          end else begin
            acc_d     = sum_c;
            smp_cnt_d = cnt_inc_c;
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (gap_last_c) state_d = Enable ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      smp_cnt_q    <= '0;
      err_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      temp_data_q  <= '0;
      temp_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      smp_cnt_q    <= smp_cnt_d;
      err_cnt_q    <= err_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      temp_data_q  <= temp_data_d;
      temp_valid_q <= temp_valid_d;
      fault_q      <= fault_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign Temp_Data    = temp_data_q;
  assign Temp_Valid   = temp_valid_q;
  assign Sensor_Fault = fault_q;
  assign Frame_Err    = frame_err_q;

endmodule
